// File: rtl/udp_mux_pkg.sv
// Shared definitions for the UDP port mux: metadata layout and FSM state types.
package udp_mux_pkg;

    localparam int META_W   = 176;
    localparam int RPORT_LO = 128;
    localparam int LPORT_LO = 144;
    localparam int LPORT_HI = 159;
    localparam int LEN_LO   = 160;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_META,
        RX_DATA,
        RX_DROP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_META,
        TX_DATA
    } tx_state_t;

endpackage

// File: rtl/udp_mux_rr_arbiter.sv
// Combinational round-robin search: first requester at or above ptr, wrapping.
// Returns the winner as one-hot and as an index; the pointer is owned by the caller.
module udp_mux_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_valid
);

    always_comb begin
        logic [IDX_W:0] cand;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        // Walk offsets from farthest to nearest so the nearest requester wins last.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NUM_CH)) begin
                cand = cand - (IDX_W + 1)'(NUM_CH);
            end
            if (req[cand[IDX_W-1:0]]) begin
                grant                   = '0;
                grant[cand[IDX_W-1:0]] = 1'b1;
                grant_idx               = cand[IDX_W-1:0];
                grant_valid             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_port_mux.sv
// Multi-channel UDP application adapter: RX steering by local port, TX round-robin packet merge.
// Optional statistics counters enabled with `define UDP_PORT_MUX_STATS_EN.
module udp_port_mux
    import udp_mux_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int NUM_CH = 4
) (
    input  logic                       net_clk,
    input  logic                       net_aresetn,
    input  logic [NUM_CH*16-1:0]       listen_ports,
`ifdef UDP_PORT_MUX_STATS_EN
    output logic [NUM_CH*32-1:0]       rx_pkt_cnt,
    output logic [31:0]                rx_drop_cnt,
`endif
    input  logic                       s_rx_meta_valid,
    output logic                       s_rx_meta_ready,
    input  logic [META_W-1:0]          s_rx_meta_data,
    input  logic                       s_rx_data_valid,
    output logic                       s_rx_data_ready,
    input  logic [WIDTH-1:0]           s_rx_data_data,
    input  logic [WIDTH/8-1:0]         s_rx_data_keep,
    input  logic                       s_rx_data_last,
    output logic [NUM_CH-1:0]          m_rx_meta_valid,
    input  logic [NUM_CH-1:0]          m_rx_meta_ready,
    output logic [NUM_CH*META_W-1:0]   m_rx_meta_data,
    output logic [NUM_CH-1:0]          m_rx_data_valid,
    input  logic [NUM_CH-1:0]          m_rx_data_ready,
    output logic [NUM_CH*WIDTH-1:0]    m_rx_data_data,
    output logic [NUM_CH*WIDTH/8-1:0]  m_rx_data_keep,
    output logic [NUM_CH-1:0]          m_rx_data_last,
    input  logic [NUM_CH-1:0]          s_tx_meta_valid,
    output logic [NUM_CH-1:0]          s_tx_meta_ready,
    input  logic [NUM_CH*META_W-1:0]   s_tx_meta_data,
    input  logic [NUM_CH-1:0]          s_tx_data_valid,
    output logic [NUM_CH-1:0]          s_tx_data_ready,
    input  logic [NUM_CH*WIDTH-1:0]    s_tx_data_data,
    input  logic [NUM_CH*WIDTH/8-1:0]  s_tx_data_keep,
    input  logic [NUM_CH-1:0]          s_tx_data_last,
    output logic                       m_tx_meta_valid,
    input  logic                       m_tx_meta_ready,
    output logic [META_W-1:0]          m_tx_meta_data,
    output logic                       m_tx_data_valid,
    input  logic                       m_tx_data_ready,
    output logic [WIDTH-1:0]           m_tx_data_data,
    output logic [WIDTH/8-1:0]         m_tx_data_keep,
    output logic                       m_tx_data_last
);

    localparam int KW    = WIDTH / 8;
    localparam int IDX_W = $clog2(NUM_CH);

    rx_state_t          rx_state;
    logic [META_W-1:0]  rx_meta_reg;
    logic [IDX_W-1:0]   rx_sel_reg;
    logic               rx_run_reg;
    logic [NUM_CH-1:0]  rx_port_match;
    logic               rx_hit;
    logic [IDX_W-1:0]   rx_hit_idx;
    logic               rx_meta_in_fire;
    logic               rx_meta_out_fire;
    logic               rx_beat_fire;

    tx_state_t          tx_state;
    logic [IDX_W-1:0]   tx_sel_reg;
    logic [NUM_CH-1:0]  tx_gnt_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [NUM_CH-1:0]  arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [META_W-1:0]  tx_meta_mux;

    // ---------------- RX steering ----------------
    // Held low for the first cycle after reset so no ready is seen while in reset.
    assign s_rx_meta_ready  = rx_run_reg && (rx_state == RX_IDLE);
    assign s_rx_data_ready  = ((rx_state == RX_DATA) && m_rx_data_ready[rx_sel_reg])
                            || (rx_state == RX_DROP);
    assign rx_meta_in_fire  = s_rx_meta_valid && s_rx_meta_ready;
    assign rx_meta_out_fire = (rx_state == RX_META) && m_rx_meta_ready[rx_sel_reg];
    assign rx_beat_fire     = s_rx_data_valid && s_rx_data_ready;

    always_comb begin
        rx_hit     = 1'b0;
        rx_hit_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rx_port_match[i]) begin
                rx_hit     = 1'b1;
                rx_hit_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) begin
            rx_state    <= RX_IDLE;
            rx_meta_reg <= '0;
            rx_sel_reg  <= '0;
            rx_run_reg  <= 1'b0;
        end else begin
            rx_run_reg <= 1'b1;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_meta_in_fire) begin
                        rx_meta_reg <= s_rx_meta_data;
                        rx_sel_reg  <= rx_hit_idx;
                        rx_state    <= rx_hit ? RX_META : RX_DROP;
                    end
                end
                RX_META: begin
                    if (rx_meta_out_fire) begin
                        rx_state <= RX_DATA;
                    end
                end
                RX_DATA, RX_DROP: begin
                    if (rx_beat_fire && s_rx_data_last) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- TX merge ----------------
    udp_mux_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req         (s_tx_meta_valid),
        .ptr         (rr_ptr_reg),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_comb begin
        tx_meta_mux = s_tx_meta_data[tx_sel_reg*META_W +: META_W];
        tx_meta_mux[LPORT_HI:LPORT_LO] = listen_ports[tx_sel_reg*16 +: 16];
    end

    assign m_tx_meta_valid = (tx_state == TX_META) && s_tx_meta_valid[tx_sel_reg];
    assign m_tx_meta_data  = tx_meta_mux;
    assign m_tx_data_valid = (tx_state == TX_DATA) && s_tx_data_valid[tx_sel_reg];
    assign m_tx_data_data  = s_tx_data_data[tx_sel_reg*WIDTH +: WIDTH];
    assign m_tx_data_keep  = s_tx_data_keep[tx_sel_reg*KW +: KW];
    assign m_tx_data_last  = s_tx_data_last[tx_sel_reg];

    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) begin
            tx_state   <= TX_IDLE;
            tx_sel_reg <= '0;
            tx_gnt_reg <= '0;
            rr_ptr_reg <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (arb_valid) begin
                        tx_sel_reg <= arb_idx;
                        tx_gnt_reg <= arb_grant;
                        tx_state   <= TX_META;
                    end
                end
                TX_META: begin
                    if (m_tx_meta_valid && m_tx_meta_ready) begin
                        rr_ptr_reg <= (tx_sel_reg == IDX_W'(NUM_CH - 1)) ? '0 : tx_sel_reg + 1'b1;
                        tx_state   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (m_tx_data_valid && m_tx_data_ready && m_tx_data_last) begin
                        tx_gnt_reg <= '0;
                        tx_state   <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------- Per-channel fan-out ----------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign rx_port_match[gi] = (listen_ports[gi*16 +: 16] == s_rx_meta_data[LPORT_HI:LPORT_LO]);

        assign m_rx_meta_valid[gi]               = (rx_state == RX_META) && (rx_sel_reg == IDX_W'(gi));
        assign m_rx_meta_data[gi*META_W +: META_W] = rx_meta_reg;
        assign m_rx_data_valid[gi]               = (rx_state == RX_DATA) && (rx_sel_reg == IDX_W'(gi))
                                                 && s_rx_data_valid;
        assign m_rx_data_data[gi*WIDTH +: WIDTH] = s_rx_data_data;
        assign m_rx_data_keep[gi*KW +: KW]       = s_rx_data_keep;
        assign m_rx_data_last[gi]                = s_rx_data_last;

        assign s_tx_meta_ready[gi] = (tx_state == TX_META) && tx_gnt_reg[gi] && m_tx_meta_ready;
        assign s_tx_data_ready[gi] = (tx_state == TX_DATA) && tx_gnt_reg[gi] && m_tx_data_ready;

`ifdef UDP_PORT_MUX_STATS_EN
        always_ff @(posedge net_clk or negedge net_aresetn) begin
            if (!net_aresetn) begin
                rx_pkt_cnt[gi*32 +: 32] <= '0;
            end else if (m_rx_meta_valid[gi] && m_rx_meta_ready[gi]
                         && (rx_pkt_cnt[gi*32 +: 32] != 32'hFFFF_FFFF)) begin
                rx_pkt_cnt[gi*32 +: 32] <= rx_pkt_cnt[gi*32 +: 32] + 32'd1;
            end
        end
`endif
    end

`ifdef UDP_PORT_MUX_STATS_EN
    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) begin
            rx_drop_cnt <= '0;
        end else if ((rx_state == RX_IDLE) && rx_meta_in_fire && !rx_hit
                     && (rx_drop_cnt != 32'hFFFF_FFFF)) begin
            rx_drop_cnt <= rx_drop_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/udp_port_mux.md
Name: udp_port_mux

Overview:
- Multi-channel application-side adapter for the UDP stack.
- RX: steers each UDP datagram (176-bit meta + data stream) to one of NUM_CH channels by destination port.
- TX: round-robin merges NUM_CH channel streams into the single UDP TX meta/data pair, one whole packet at a time.
- Sits between the UDP stack role interface and up to NUM_CH independent user roles.

Parameters:
- WIDTH, 64: data bus width in bits; keep width is WIDTH/8.
- NUM_CH, 4: number of user channels, 2..16.
- META_W, 176: UDP metadata width. Layout: [127:0] remote IP, [143:128] remote port, [159:144] local port, [175:160] payload length.

Ports:
- net_clk  in  1  clock.
- net_aresetn  in  1  asynchronous active-low reset.
- listen_ports  in  NUM_CH*16  local port of channel i at [16i+15:16i]; sampled per packet.
- s_rx_meta_valid/ready/data  in/out/in  1/1/META_W  RX meta from the stack.
- s_rx_data_valid/ready/data/keep/last  in/out/in/in/in  1/1/WIDTH/WIDTH/8/1  RX payload from the stack.
- m_rx_meta_valid/ready/data  out/in/out  NUM_CH/NUM_CH/NUM_CH*META_W  per-channel RX meta.
- m_rx_data_valid/ready/data/keep/last  out/in/out/out/out  NUM_CH/NUM_CH/NUM_CH*WIDTH/NUM_CH*WIDTH/8/NUM_CH  per-channel RX payload.
- s_tx_meta_valid/ready/data  in/out/in  NUM_CH/NUM_CH/NUM_CH*META_W  per-channel TX meta.
- s_tx_data_valid/ready/data/keep/last  in/out/in/in/in  per-channel widths as RX  per-channel TX payload.
- m_tx_meta_valid/ready/data  out/in/out  1/1/META_W  merged TX meta to the stack.
- m_tx_data_valid/ready/data/keep/last  out/in/out/out/out  1/1/WIDTH/WIDTH/8/1  merged TX payload.

Behaviour:
- Reset: all valid and ready outputs 0; both FSMs in IDLE; RR pointer 0; counters 0. Reset mid-packet abandons the packet with no tlast emitted; the downstream consumer is reset together with this block.
- All handshakes are AXI-Stream: a transfer occurs when valid && ready; valid never depends on ready; payload held stable while valid && !ready.
- RX FSM states: RX_IDLE, RX_META, RX_DATA, RX_DROP.
  - RX_IDLE: s_rx_meta_ready=1. On a meta transfer, register the meta and compare local port [159:144] against every listen_ports entry.
  - On a match, latch the lowest matching index as rx_sel and go to RX_META. On no match, go to RX_DROP.
  - RX_META: m_rx_meta_valid[rx_sel]=1 with the registered meta; after the transfer go to RX_DATA. Meta latency from input to output is 1 cycle.
  - RX_DATA: combinational pass-through of the data beat to channel rx_sel; s_rx_data_ready = m_rx_data_ready[rx_sel]; other channels see valid 0. A beat with last returns the FSM to RX_IDLE.
  - RX_DROP: s_rx_data_ready=1; discard beats until last, then RX_IDLE.
  - Zero-length datagrams still carry one data beat with last (stack contract); no special case.
- TX FSM states: TX_IDLE, TX_META, TX_DATA.
  - TX_IDLE: choose the first channel with s_tx_meta_valid, searching from rr_ptr upward with wrap. Latch it as tx_sel and go to TX_META. No request means stay in TX_IDLE.
  - TX_META: connect s_tx_meta of tx_sel to m_tx_meta, with local port field [159:144] overwritten by listen_ports[tx_sel]. After the transfer go to TX_DATA and set rr_ptr = (tx_sel+1) mod NUM_CH.
  - TX_DATA: pass-through of s_tx_data[tx_sel] to m_tx_data until a beat with last, then TX_IDLE.
  - Non-selected channels see ready 0. The grant is held for the whole packet, so beats never interleave.
- RX and TX are fully independent and may be active in the same cycle.
- Unconnected channels must tie their ready inputs to 1.

Optional Feature:
- Macro UDP_PORT_MUX_STATS_EN.
- When defined: extra outputs rx_pkt_cnt (NUM_CH*32) and rx_drop_cnt (32).
  - rx_pkt_cnt[i] increments on each RX_META transfer to channel i.
  - rx_drop_cnt increments on each entry into RX_DROP.
  - Counters saturate at 32'hFFFFFFFF.
- When undefined: neither port nor counter logic exists.

Decomposition:
- Package udp_mux_pkg holds:
  - META_W;
  - field offsets LPORT_LO=144, LPORT_HI=159, RPORT_LO=128, LEN_LO=160;
  - typedef enums rx_state_t and tx_state_t.
- One sub-module, udp_mux_rr_arbiter: NUM_CH request vector and rr_ptr in; one-hot grant plus index out; purely combinational search; the pointer register stays in the parent.

Test Plan:
- listen_ports={5003,5002,5001,5000}; RX meta local port 5002 with 3 beats -> meta appears on channel 2 one cycle later; 3 beats on channel 2 with last on beat 3; all other channels stay valid 0.
- RX meta local port 7777 with 4 beats -> no channel valid; s_rx_data_ready=1 for all 4 beats; with STATS_EN, rx_drop_cnt=1.
- Channels 0, 1 and 3 request TX simultaneously with 2-beat packets -> TX order is 0, 1, 3, then 0 again if it re-requests. Output local port fields read 5000, 5001 and 5003. No interleaving while m_tx_data_ready toggles 1,0,1.
- listen_ports[1]=listen_ports[2]=6000; RX to port 6000 -> delivered to channel 1 only.
- m_rx_data_ready[0] held 0 for 10 cycles mid-packet -> s_rx_data_ready=0 and data stable for those cycles; an RX packet arriving concurrently with active TX traffic completes on both paths independently.
- Assert net_aresetn low during RX_DATA beat 2 -> all valids 0 within the reset cycle; after release, a new packet is routed correctly from RX_IDLE.
